// File: rtl/counter_bus_pkg.sv
// Shared types and constants for the counter bus scheduler.
package counter_bus_pkg;

    localparam int DEF_WIDTH = 8;

    // Scheduler slot phases: pick a winner, drive the counter, bus turnaround.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_e;

    // Operation requested by the granted requester.
    typedef enum logic {
        OP_READ = 1'b0,
        OP_LOAD = 1'b1
    } op_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: the requester at index ptr has the
// highest priority, then ptr+1, ... wrapping around modulo N.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        int cand;
        // NOTE: every output gets a default before the loop, so no latch is inferred.
        gnt     = '0;
        gnt_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = int'(ptr) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (req[IDX_W'(cand)]) begin
                gnt                 = '0;
                gnt[IDX_W'(cand)]   = 1'b1;
                gnt_idx             = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/counter_bus_sched.sv
// Time-shares one count bus and one parallel-load bus between NUM_CNT counters.
// Each slot is IDLE (arbitrate) -> DRIVE (oe or load strobe) -> TURN (no oe,
// response pulse), which guarantees a zero-oe cycle between different counters.
module counter_bus_sched
    import counter_bus_pkg::*;
#(
    parameter int NUM_CNT = 4,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SETTLE  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CNT-1:0]       req,
    input  logic [NUM_CNT-1:0]       req_we,
    input  logic [NUM_CNT*WIDTH-1:0] req_wdata,
    output logic [NUM_CNT-1:0]       req_ack,
    output logic [NUM_CNT-1:0]       rsp_valid,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [NUM_CNT-1:0]       cnt_oe,
    output logic [NUM_CNT-1:0]       cnt_load,
    output logic [WIDTH-1:0]         cnt_d,
    input  logic [WIDTH-1:0]         cnt_bus
);

    localparam int                IDX_W       = $clog2(NUM_CNT);
    localparam logic [1:0]        SETTLE_LAST = 2'(SETTLE);
    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NUM_CNT - 1);

    state_e               state_q,     state_d;
    op_e                  op_q,        op_d;
    logic [NUM_CNT-1:0]   win_oh_q,    win_oh_d;
    logic [IDX_W-1:0]     win_idx_q,   win_idx_d;
    logic [WIDTH-1:0]     wdata_q,     wdata_d;
    logic [1:0]           settle_q,    settle_d;
    logic [IDX_W-1:0]     last_q,      last_d;
    logic [NUM_CNT-1:0]   req_ack_q,   req_ack_d;
    logic [NUM_CNT-1:0]   rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]     rsp_data_q,  rsp_data_d;
    logic [NUM_CNT-1:0]   cnt_oe_q,    cnt_oe_d;
    logic [NUM_CNT-1:0]   cnt_load_q,  cnt_load_d;
    logic [WIDTH-1:0]     cnt_d_q,     cnt_d_d;

    logic [IDX_W-1:0]     rr_ptr;
    logic [NUM_CNT-1:0]   gnt;
    logic [IDX_W-1:0]     gnt_idx;
    logic [WIDTH-1:0]     sel_wdata;
    logic                 sel_we;

    // Search starts one past the last winner; reset leaves requester 0 on top.
    assign rr_ptr = (last_q == LAST_IDX) ? '0 : last_q + 1'b1;

    rr_arbiter #(
        .N     (NUM_CNT),
        .IDX_W (IDX_W)
    ) u_arb (
        .req     (req),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Select the winner's op and load data using the one-hot grant.
    always_comb begin
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int k = 0; k < NUM_CNT; k++) begin
            if (gnt[k]) begin
                sel_wdata = req_wdata[k*WIDTH +: WIDTH];
                sel_we    = req_we[k];
            end
        end
    end

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        win_oh_d    = win_oh_q;
        win_idx_d   = win_idx_q;
        wdata_d     = wdata_q;
        settle_d    = settle_q;
        last_d      = last_q;
        rsp_data_d  = rsp_data_q;
        cnt_d_d     = cnt_d_q;
        req_ack_d   = '0;
        rsp_valid_d = '0;
        cnt_oe_d    = '0;
        cnt_load_d  = '0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d   = DRIVE;
                    op_d      = sel_we ? OP_LOAD : OP_READ;
                    win_oh_d  = gnt;
                    win_idx_d = gnt_idx;
                    wdata_d   = sel_wdata;
                    settle_d  = '0;
                    req_ack_d = gnt;
                    if (sel_we) begin
                        cnt_load_d = gnt;
                        cnt_d_d    = sel_wdata;
                    end else begin
                        cnt_oe_d = gnt;
                    end
                end
            end
            DRIVE: begin
                if (op_q == OP_LOAD) begin
                    rsp_valid_d = win_oh_q;
                    rsp_data_d  = wdata_q;
                    state_d     = TURN;
                end else if (settle_q == SETTLE_LAST) begin
                    // Last oe cycle: the bus is captured on this edge.
                    rsp_valid_d = win_oh_q;
                    rsp_data_d  = cnt_bus;
                    state_d     = TURN;
                end else begin
                    settle_d = settle_q + 2'd1;
                    cnt_oe_d = win_oh_q;
                end
            end
            TURN: begin
                last_d  = win_idx_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops oe/load immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= OP_READ;
            win_oh_q    <= '0;
            win_idx_q   <= '0;
            wdata_q     <= '0;
            settle_q    <= '0;
            last_q      <= LAST_IDX;
            req_ack_q   <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            cnt_oe_q    <= '0;
            cnt_load_q  <= '0;
            cnt_d_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            op_q        <= op_d;
            win_oh_q    <= win_oh_d;
            win_idx_q   <= win_idx_d;
            wdata_q     <= wdata_d;
            settle_q    <= settle_d;
            last_q      <= last_d;
            req_ack_q   <= req_ack_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            cnt_oe_q    <= cnt_oe_d;
            cnt_load_q  <= cnt_load_d;
            cnt_d_q     <= cnt_d_d;
        end
    end

    assign req_ack   = req_ack_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign cnt_oe    = cnt_oe_q;
    assign cnt_load  = cnt_load_q;
    assign cnt_d     = cnt_d_q;

endmodule

// File: tb/tb_counter_bus_sched.sv
// Bench for counter_bus_sched: directed scenarios plus a randomized run
// compared cycle by cycle against a slot-timing reference model.
module tb_counter_bus_sched;

    localparam int NC = 4;
    localparam int W  = 8;
    localparam int S  = 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [NC-1:0]     req, req_we;
    logic [NC*W-1:0]   req_wdata;
    logic [NC-1:0]     req_ack, rsp_valid, cnt_oe, cnt_load;
    logic [W-1:0]      rsp_data, cnt_d, cnt_bus;

    // Counter bank environment.
    logic [W-1:0]      cnt_val [NC];
    logic [NC-1:0]     cnt_en, cnt_up, preset_en;
    logic [W-1:0]      preset_val;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    counter_bus_sched #(.NUM_CNT(NC), .WIDTH(W), .SETTLE(S)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_we    (req_we),
        .req_wdata (req_wdata),
        .req_ack   (req_ack),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .cnt_oe    (cnt_oe),
        .cnt_load  (cnt_load),
        .cnt_d     (cnt_d),
        .cnt_bus   (cnt_bus)
    );

    // Loadable up/down counters; load wins over counting.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NC; k++) begin
            if (preset_en[k])      cnt_val[k] <= preset_val;
            else if (cnt_load[k])  cnt_val[k] <= cnt_d;
            else if (cnt_en[k])    cnt_val[k] <= cnt_up[k] ? cnt_val[k] + 8'd1 : cnt_val[k] - 8'd1;
        end
    end

    // Tri-state bus: undriven (X) unless exactly one counter is enabled.
    always_comb begin
        cnt_bus = 'x;
        for (int k = 0; k < NC; k++) begin
            if (cnt_oe == (NC'(1) << k)) cnt_bus = cnt_val[k];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int oh_idx(input logic [NC-1:0] v);
        for (int i = 0; i < NC; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; req_we = '0; req_wdata = '0;
        cnt_en = '0; cnt_up = '0; preset_en = '1; preset_val = '0;
        tick(); tick();
        reset = 1'b0; preset_en = '0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; req = '0; req_we = '0; req_wdata = '0;
        cnt_en = '0; cnt_up = '0; preset_en = '1; preset_val = '0;
        tick();
        n_tests++; if (req_ack   !== '0) begin n_fail++; $display("FAIL reset_ack got=%b exp=0", req_ack); end
        n_tests++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        n_tests++; if (cnt_oe    !== '0) begin n_fail++; $display("FAIL reset_oe got=%b exp=0", cnt_oe); end
        n_tests++; if (cnt_load  !== '0) begin n_fail++; $display("FAIL reset_load got=%b exp=0", cnt_load); end
        n_tests++; if (rsp_data  !== '0) begin n_fail++; $display("FAIL reset_rsp_data got=%h exp=00", rsp_data); end
        n_tests++; if (cnt_d     !== '0) begin n_fail++; $display("FAIL reset_cnt_d got=%h exp=00", cnt_d); end
        reset = 1'b0; preset_en = '0;
        tick();
    endtask

    task automatic test_read();
        preset_en = 4'b0100; preset_val = 8'h5A;
        tick();
        preset_en = '0;
        req = 4'b0100; req_we = '0;
        tick();  // DRIVE cycle 1
        n_tests++; if (req_ack !== 4'b0100) begin n_fail++; $display("FAIL read_ack got=%b exp=0100", req_ack); end
        n_tests++; if (cnt_oe  !== 4'b0100) begin n_fail++; $display("FAIL read_oe1 got=%b exp=0100", cnt_oe); end
        tick();  // DRIVE cycle 2
        req = '0;
        n_tests++; if (req_ack !== 4'b0000) begin n_fail++; $display("FAIL read_ack_pulse got=%b exp=0000", req_ack); end
        n_tests++; if (cnt_oe  !== 4'b0100) begin n_fail++; $display("FAIL read_oe2 got=%b exp=0100", cnt_oe); end
        tick();  // TURN
        n_tests++; if (cnt_oe    !== 4'b0000) begin n_fail++; $display("FAIL read_turn_oe got=%b exp=0000", cnt_oe); end
        n_tests++; if (rsp_valid !== 4'b0100) begin n_fail++; $display("FAIL read_rsp_valid got=%b exp=0100", rsp_valid); end
        n_tests++; if (rsp_data  !== 8'h5A)   begin n_fail++; $display("FAIL read_rsp_data got=%h exp=5a", rsp_data); end
        tick();
        n_tests++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL read_rsp_pulse got=%b exp=0000", rsp_valid); end
        n_tests++; if (rsp_data  !== 8'h5A)   begin n_fail++; $display("FAIL read_rsp_hold got=%h exp=5a", rsp_data); end
    endtask

    task automatic test_load();
        bit          got;
        logic [W-1:0] data;
        req = 4'b0010; req_we = 4'b0010;
        req_wdata = {8'h44, 8'h22, 8'hC3, 8'h11};
        tick();  // DRIVE
        n_tests++; if (req_ack  !== 4'b0010) begin n_fail++; $display("FAIL load_ack got=%b exp=0010", req_ack); end
        n_tests++; if (cnt_load !== 4'b0010) begin n_fail++; $display("FAIL load_strobe got=%b exp=0010", cnt_load); end
        n_tests++; if (cnt_d    !== 8'hC3)   begin n_fail++; $display("FAIL load_cnt_d got=%h exp=c3", cnt_d); end
        n_tests++; if (cnt_oe   !== 4'b0000) begin n_fail++; $display("FAIL load_oe got=%b exp=0000", cnt_oe); end
        tick();  // TURN
        req = '0; req_we = '0;
        n_tests++; if (cnt_load  !== 4'b0000) begin n_fail++; $display("FAIL load_strobe_pulse got=%b exp=0000", cnt_load); end
        n_tests++; if (rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL load_rsp_valid got=%b exp=0010", rsp_valid); end
        n_tests++; if (rsp_data  !== 8'hC3)   begin n_fail++; $display("FAIL load_rsp_data got=%h exp=c3", rsp_data); end
        tick();  // IDLE: read the counter back
        req = 4'b0010;
        got = 1'b0; data = '0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (req_ack[1]) req = '0;
            if (rsp_valid[1]) begin got = 1'b1; data = rsp_data; end
        end
        req = '0;
        n_tests++; if (!got) begin n_fail++; $display("FAIL load_readback_timeout got=none exp=rsp_valid[1]"); end
        n_tests++; if (data !== 8'hC3) begin n_fail++; $display("FAIL load_readback got=%h exp=c3", data); end
        n_tests++; if (cnt_d !== 8'hC3) begin n_fail++; $display("FAIL load_cnt_d_hold got=%h exp=c3", cnt_d); end
        tick();
    endtask

    task automatic test_rr();
        int acks [5];
        int ack_cyc [5];
        int n_ack, zeros;
        logic [NC-1:0] last_oe;
        do_reset();
        req = 4'b1111; req_we = '0;
        n_ack = 0; zeros = 0; last_oe = '0;
        for (int c = 0; c < 40 && n_ack < 5; c++) begin
            tick();
            if (cnt_oe == '0) zeros++;
            else begin
                if (last_oe != '0 && cnt_oe != last_oe) begin
                    n_tests++;
                    if (zeros < 1) begin n_fail++; $display("FAIL rr_turnaround zero_cycles=%0d exp>=1", zeros); end
                end
                last_oe = cnt_oe; zeros = 0;
            end
            if (req_ack != '0) begin
                acks[n_ack] = oh_idx(req_ack); ack_cyc[n_ack] = c; n_ack++;
            end
        end
        req = '0;
        n_tests++; if (n_ack != 5) begin n_fail++; $display("FAIL rr_timeout acks=%0d exp=5", n_ack); end
        for (int i = 0; i < n_ack; i++) begin
            n_tests++;
            if (acks[i] != i % NC) begin n_fail++; $display("FAIL rr_order grant%0d got=%0d exp=%0d", i, acks[i], i % NC); end
            if (i > 0) begin
                n_tests++;
                if (ack_cyc[i] - ack_cyc[i-1] != S + 3) begin
                    n_fail++; $display("FAIL rr_slot_len got=%0d exp=%0d", ack_cyc[i] - ack_cyc[i-1], S + 3);
                end
            end
        end
        repeat (6) tick();
    endtask

    task automatic test_count_wrap();
        preset_en = 4'b1000; preset_val = 8'hFF;
        req = 4'b1000; req_we = '0;
        tick();  // DRIVE 1: counter holds FF, starts counting up
        preset_en = '0; cnt_en = 4'b1000; cnt_up = 4'b1000;
        tick();  // DRIVE 2: counter now 00, sampled at the closing edge
        req = '0;
        tick();  // TURN
        n_tests++; if (rsp_valid !== 4'b1000) begin n_fail++; $display("FAIL wrap_rsp_valid got=%b exp=1000", rsp_valid); end
        n_tests++; if (rsp_data !== 8'h00) begin n_fail++; $display("FAIL wrap_rsp_data got=%h exp=00", rsp_data); end
        n_tests++; if ($isunknown(rsp_data)) begin n_fail++; $display("FAIL wrap_rsp_x got=%h exp=known", rsp_data); end
        cnt_en = '0;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        bit saw_r2, saw_r0;
        req = 4'b0100; req_we = '0;
        tick();  // DRIVE
        n_tests++; if (cnt_oe !== 4'b0100) begin n_fail++; $display("FAIL rmid_oe_before got=%b exp=0100", cnt_oe); end
        #2 reset = 1'b1;
        req = 4'b1111;
        #1;
        n_tests++; if (cnt_oe !== 4'b0000) begin n_fail++; $display("FAIL rmid_oe_async got=%b exp=0000", cnt_oe); end
        tick();
        n_tests++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL rmid_rsp got=%b exp=0000", rsp_valid); end
        reset = 1'b0;
        tick();
        n_tests++; if (req_ack !== 4'b0001) begin n_fail++; $display("FAIL rmid_first_grant got=%b exp=0001", req_ack); end
        req = '0;
        saw_r2 = 1'b0; saw_r0 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp_valid[2]) saw_r2 = 1'b1;
            if (rsp_valid[0]) saw_r0 = 1'b1;
        end
        n_tests++; if (saw_r2) begin n_fail++; $display("FAIL rmid_replay got=rsp_valid[2] exp=none"); end
        n_tests++; if (!saw_r0) begin n_fail++; $display("FAIL rmid_rsp0 got=none exp=rsp_valid[0]"); end
    endtask

    task automatic test_random();
        // Reference model: slot bookkeeping by phase within the current slot.
        bit            slot_on, is_load;
        int            ph, w, last;
        logic [W-1:0]  wdata, sampled, exp_rsp_data, exp_cnt_d;
        logic [NC-1:0] exp_ack, exp_oe, exp_load, exp_rv, oh;
        logic [NC-1:0] pend, drop_next, we_r, last_oe;
        logic [NC*W-1:0] wd_r;
        bit            zero_seen;
        int            ack_q [$];
        int            got_i;

        do_reset();
        slot_on = 0; is_load = 0; ph = 0; w = 0; last = NC - 1;
        wdata = '0; sampled = '0; exp_rsp_data = '0; exp_cnt_d = '0;
        pend = '0; drop_next = '0; we_r = '0; wd_r = '0;
        last_oe = '0; zero_seen = 1'b1;

        for (int cyc = 0; cyc < 10000; cyc++) begin
            exp_ack = '0; exp_oe = '0; exp_load = '0; exp_rv = '0;
            if (slot_on) begin
                ph++;
                oh = NC'(1) << w;
                if (ph == 1) exp_ack = oh;
                if (!is_load && ph >= 1 && ph <= S + 1) exp_oe = oh;
                if (is_load && ph == 1) begin exp_load = oh; exp_cnt_d = wdata; end
                if (ph == (is_load ? 2 : S + 2)) begin
                    exp_rv = oh; exp_rsp_data = is_load ? wdata : sampled;
                end
                if (ph == (is_load ? 3 : S + 3)) slot_on = 0;
            end

            n_tests++; if (req_ack   !== exp_ack)  begin n_fail++; $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", cyc, req_ack, exp_ack); end
            n_tests++; if (cnt_oe    !== exp_oe)   begin n_fail++; $display("FAIL rnd_oe cyc=%0d got=%b exp=%b", cyc, cnt_oe, exp_oe); end
            n_tests++; if (cnt_load  !== exp_load) begin n_fail++; $display("FAIL rnd_load cyc=%0d got=%b exp=%b", cyc, cnt_load, exp_load); end
            n_tests++; if (rsp_valid !== exp_rv)   begin n_fail++; $display("FAIL rnd_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_rv); end
            n_tests++; if (rsp_data  !== exp_rsp_data) begin n_fail++; $display("FAIL rnd_rsp_data cyc=%0d got=%h exp=%h", cyc, rsp_data, exp_rsp_data); end
            n_tests++; if (cnt_d     !== exp_cnt_d) begin n_fail++; $display("FAIL rnd_cnt_d cyc=%0d got=%h exp=%h", cyc, cnt_d, exp_cnt_d); end

            // Invariants on the counter-side strobes.
            n_tests++;
            if (!$onehot0(cnt_oe) || !$onehot0(cnt_load) || (|cnt_oe && |cnt_load)) begin
                n_fail++; $display("FAIL rnd_onehot cyc=%0d oe=%b load=%b", cyc, cnt_oe, cnt_load);
            end
            if (cnt_oe != '0) begin
                if (last_oe != '0 && cnt_oe != last_oe) begin
                    n_tests++;
                    if (!zero_seen) begin n_fail++; $display("FAIL rnd_turnaround cyc=%0d got=%b prev=%b", cyc, cnt_oe, last_oe); end
                end
                last_oe = cnt_oe; zero_seen = 1'b0;
            end else begin
                zero_seen = 1'b1;
            end

            // Every ack is matched by exactly one response to the same index.
            if (req_ack != '0) ack_q.push_back(oh_idx(req_ack));
            if (rsp_valid != '0) begin
                n_tests++;
                got_i = (ack_q.size() > 0) ? ack_q.pop_front() : -1;
                if (got_i != oh_idx(rsp_valid)) begin
                    n_fail++; $display("FAIL rnd_ack_rsp cyc=%0d rsp=%0d exp=%0d", cyc, oh_idx(rsp_valid), got_i);
                end
            end

            // Requesters: hold until ack, drop the cycle after, re-request at random.
            for (int j = 0; j < NC; j++) begin
                if (drop_next[j]) begin pend[j] = 1'b0; drop_next[j] = 1'b0; end
                else if (exp_ack[j]) drop_next[j] = 1'b1;
                else if (!pend[j] && $urandom_range(0, 3) == 0) begin
                    pend[j] = 1'b1;
                    we_r[j] = 1'($urandom_range(0, 1));
                    wd_r[j*W +: W] = 8'($urandom);
                end
            end
            req = pend; req_we = we_r; req_wdata = wd_r;
            cnt_en = NC'($urandom); cnt_up = NC'($urandom);

            if (slot_on && !is_load && ph == S + 1) sampled = cnt_val[w];
            if (!slot_on && req != '0) begin
                for (int i = NC; i >= 1; i--) begin
                    if (req[(last + i) % NC]) w = (last + i) % NC;
                end
                slot_on = 1; ph = 0; last = w;
                is_load = req_we[w];
                wdata   = req_wdata[w*W +: W];
            end
            tick();
        end
        req = '0; cnt_en = '0;
        repeat (8) tick();
    endtask

    initial begin
        test_reset();
        test_read();
        test_load();
        test_rr();
        test_count_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
